// File: rtl/pdp8_memory.sv
// pdp8_memory: unified 4K x 12-bit PDP-8 main memory.
// Two independent registered read ports (fetch, execute), one execute
// write port and a preload port that has priority over execute writes.
// Reads are write-first: a read of the word being written on the same
// edge returns the new data. Saturating counters track port traffic.
// The memory array is deliberately left untouched by reset so a preloaded
// program image survives a restart.

module pdp8_memory #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,

  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,

  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,

  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,

  output logic                  wr_drop,
  output logic [CNT_WIDTH-1:0]  ifu_rd_count,
  output logic [CNT_WIDTH-1:0]  exec_rd_count,
  output logic [CNT_WIDTH-1:0]  exec_wr_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  exec_commit;
  logic                  exec_drop;
  logic [DATA_WIDTH-1:0] ifu_next;
  logic [DATA_WIDTH-1:0] exec_next;

  // Saturating increment: all-ones is sticky so counters never wrap.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
    if (&value) begin
      return value;
    end
    return value + CNT_WIDTH'(1);
  endfunction

  // Arbitrate the single array write port (preload wins) and build the
  // write-first read values for both read ports.
  always_comb begin
    exec_commit = exec_wr_req && !load_en;
    exec_drop   = exec_wr_req && load_en;
    wr_en       = load_en || exec_wr_req;
    wr_addr     = load_en ? load_addr : exec_wr_addr;
    wr_data     = load_en ? load_data : exec_wr_data;

    ifu_next = mem[ifu_rd_addr];
    if (wr_en && (wr_addr == ifu_rd_addr)) begin
      ifu_next = wr_data;
    end

    exec_next = mem[exec_rd_addr];
    if (wr_en && (wr_addr == exec_rd_addr)) begin
      exec_next = wr_data;
    end
  end

  // Array write; suppressed while reset is high so no write commits
  // during reset, but the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Fetch read port: registered data that holds until the next request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifu_rd_data <= '0;
    end else if (ifu_rd_req) begin
      ifu_rd_data <= ifu_next;
    end
  end

  // Execute read port: same behaviour as fetch, fully independent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_rd_data <= '0;
    end else if (exec_rd_req) begin
      exec_rd_data <= exec_next;
    end
  end

  // Sticky flag recording that a preload displaced an execute write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_drop <= 1'b0;
    end else if (exec_drop) begin
      wr_drop <= 1'b1;
    end
  end

  // Traffic counters; dropped execute writes are not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifu_rd_count  <= '0;
      exec_rd_count <= '0;
      exec_wr_count <= '0;
    end else begin
      if (ifu_rd_req) begin
        ifu_rd_count <= sat_inc(ifu_rd_count);
      end
      if (exec_rd_req) begin
        exec_rd_count <= sat_inc(exec_rd_count);
      end
      if (exec_commit) begin
        exec_wr_count <= sat_inc(exec_wr_count);
      end
    end
  end

endmodule

// File: tb/tb_pdp8_memory.sv
// tb_pdp8_memory: directed self-checking bench for pdp8_memory.
// Inputs change on the falling edge; outputs are sampled on the falling
// edge after the rising edge that consumed the stimulus.

module tb_pdp8_memory;

  logic        clk;
  logic        reset;
  logic        ifu_rd_req;
  logic [11:0] ifu_rd_addr;
  logic [11:0] ifu_rd_data;
  logic        exec_rd_req;
  logic [11:0] exec_rd_addr;
  logic [11:0] exec_rd_data;
  logic        exec_wr_req;
  logic [11:0] exec_wr_addr;
  logic [11:0] exec_wr_data;
  logic        load_en;
  logic [11:0] load_addr;
  logic [11:0] load_data;
  logic        wr_drop;
  logic [15:0] ifu_rd_count;
  logic [15:0] exec_rd_count;
  logic [15:0] exec_wr_count;

  int checks;
  int errors;

  pdp8_memory #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(12),
    .CNT_WIDTH (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ifu_rd_req   (ifu_rd_req),
    .ifu_rd_addr  (ifu_rd_addr),
    .ifu_rd_data  (ifu_rd_data),
    .exec_rd_req  (exec_rd_req),
    .exec_rd_addr (exec_rd_addr),
    .exec_rd_data (exec_rd_data),
    .exec_wr_req  (exec_wr_req),
    .exec_wr_addr (exec_wr_addr),
    .exec_wr_data (exec_wr_data),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .wr_drop      (wr_drop),
    .ifu_rd_count (ifu_rd_count),
    .exec_rd_count(exec_rd_count),
    .exec_wr_count(exec_wr_count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    ifu_rd_req   = 1'b0;
    ifu_rd_addr  = '0;
    exec_rd_req  = 1'b0;
    exec_rd_addr = '0;
    exec_wr_req  = 1'b0;
    exec_wr_addr = '0;
    exec_wr_data = '0;
    load_en      = 1'b0;
    load_addr    = '0;
    load_data    = '0;
  endtask

  // Let one rising edge consume the current inputs, then return to idle.
  task automatic step();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic preload(input logic [11:0] addr, input logic [11:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #12;
    checks++; if (ifu_rd_data !== 12'o0) begin errors++; $display("[TB] FAIL reset_ifu_data got %0o expected 0", ifu_rd_data); end
    checks++; if (exec_rd_data !== 12'o0) begin errors++; $display("[TB] FAIL reset_exec_data got %0o expected 0", exec_rd_data); end
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_drop got %0b expected 0", wr_drop); end
    checks++; if (ifu_rd_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_ifu_count got %0d expected 0", ifu_rd_count); end
    checks++; if (exec_rd_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_exec_rd_count got %0d expected 0", exec_rd_count); end
    checks++; if (exec_wr_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_exec_wr_count got %0d expected 0", exec_wr_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_preload_fetch();
    preload(12'o0200, 12'o1234);
    preload(12'o0010, 12'o0001);
    preload(12'o7777, 12'o7777);
    checks++; if (ifu_rd_count !== 16'd0) begin errors++; $display("[TB] FAIL preload_no_count got %0d expected 0", ifu_rd_count); end
    ifu_rd_req  = 1'b1;
    ifu_rd_addr = 12'o0200;
    step();
    checks++; if (ifu_rd_data !== 12'o1234) begin errors++; $display("[TB] FAIL fetch_0200 got %0o expected 1234", ifu_rd_data); end
    checks++; if (ifu_rd_count !== 16'd1) begin errors++; $display("[TB] FAIL fetch_count got %0d expected 1", ifu_rd_count); end
    checks++; if (exec_rd_data !== 12'o0) begin errors++; $display("[TB] FAIL fetch_exec_untouched got %0o expected 0", exec_rd_data); end
    ifu_rd_addr = 12'o0010;
    step();
    step();
    checks++; if (ifu_rd_data !== 12'o1234) begin errors++; $display("[TB] FAIL fetch_hold got %0o expected 1234", ifu_rd_data); end
    checks++; if (ifu_rd_count !== 16'd1) begin errors++; $display("[TB] FAIL fetch_hold_count got %0d expected 1", ifu_rd_count); end
  endtask

  task automatic test_write_read_same();
    pulse_reset();
    exec_wr_req  = 1'b1;
    exec_wr_addr = 12'o0300;
    exec_wr_data = 12'o5555;
    exec_rd_req  = 1'b1;
    exec_rd_addr = 12'o0300;
    ifu_rd_req   = 1'b1;
    ifu_rd_addr  = 12'o0300;
    step();
    checks++; if (ifu_rd_data !== 12'o5555) begin errors++; $display("[TB] FAIL fwd_ifu got %0o expected 5555", ifu_rd_data); end
    checks++; if (exec_rd_data !== 12'o5555) begin errors++; $display("[TB] FAIL fwd_exec got %0o expected 5555", exec_rd_data); end
    checks++; if (exec_wr_count !== 16'd1) begin errors++; $display("[TB] FAIL fwd_wr_count got %0d expected 1", exec_wr_count); end
    checks++; if (exec_rd_count !== 16'd1) begin errors++; $display("[TB] FAIL fwd_rd_count got %0d expected 1", exec_rd_count); end
    checks++; if (ifu_rd_count !== 16'd1) begin errors++; $display("[TB] FAIL fwd_ifu_count got %0d expected 1", ifu_rd_count); end
    exec_rd_req  = 1'b1;
    exec_rd_addr = 12'o0300;
    step();
    checks++; if (exec_rd_data !== 12'o5555) begin errors++; $display("[TB] FAIL write_committed got %0o expected 5555", exec_rd_data); end
    checks++; if (exec_rd_count !== 16'd2) begin errors++; $display("[TB] FAIL write_rd_count got %0d expected 2", exec_rd_count); end
  endtask

  task automatic test_dual_read();
    pulse_reset();
    ifu_rd_req   = 1'b1;
    ifu_rd_addr  = 12'o0010;
    exec_rd_req  = 1'b1;
    exec_rd_addr = 12'o7777;
    step();
    checks++; if (ifu_rd_data !== 12'o0001) begin errors++; $display("[TB] FAIL dual_ifu got %0o expected 0001", ifu_rd_data); end
    checks++; if (exec_rd_data !== 12'o7777) begin errors++; $display("[TB] FAIL dual_exec got %0o expected 7777", exec_rd_data); end
    checks++; if (ifu_rd_count !== 16'd1) begin errors++; $display("[TB] FAIL dual_ifu_count got %0d expected 1", ifu_rd_count); end
    checks++; if (exec_rd_count !== 16'd1) begin errors++; $display("[TB] FAIL dual_exec_count got %0d expected 1", exec_rd_count); end
  endtask

  task automatic test_load_collision();
    pulse_reset();
    load_en      = 1'b1;
    load_addr    = 12'o0400;
    load_data    = 12'o1111;
    exec_wr_req  = 1'b1;
    exec_wr_addr = 12'o0400;
    exec_wr_data = 12'o2222;
    exec_rd_req  = 1'b1;
    exec_rd_addr = 12'o0400;
    step();
    checks++; if (exec_rd_data !== 12'o1111) begin errors++; $display("[TB] FAIL load_fwd got %0o expected 1111", exec_rd_data); end
    checks++; if (wr_drop !== 1'b1) begin errors++; $display("[TB] FAIL drop_set got %0b expected 1", wr_drop); end
    checks++; if (exec_wr_count !== 16'd0) begin errors++; $display("[TB] FAIL drop_wr_count got %0d expected 0", exec_wr_count); end
    ifu_rd_req  = 1'b1;
    ifu_rd_addr = 12'o0400;
    step();
    checks++; if (ifu_rd_data !== 12'o1111) begin errors++; $display("[TB] FAIL load_wins got %0o expected 1111", ifu_rd_data); end
    checks++; if (wr_drop !== 1'b1) begin errors++; $display("[TB] FAIL drop_sticky got %0b expected 1", wr_drop); end
    exec_wr_req  = 1'b1;
    exec_wr_addr = 12'o0500;
    exec_wr_data = 12'o4321;
    step();
    checks++; if (exec_wr_count !== 16'd1) begin errors++; $display("[TB] FAIL plain_wr_count got %0d expected 1", exec_wr_count); end
    checks++; if (wr_drop !== 1'b1) begin errors++; $display("[TB] FAIL drop_after_write got %0b expected 1", wr_drop); end
  endtask

  task automatic test_async_reset();
    preload(12'o0600, 12'o0707);
    ifu_rd_req   = 1'b1;
    ifu_rd_addr  = 12'o0200;
    exec_rd_req  = 1'b1;
    exec_rd_addr = 12'o7777;
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ifu_rd_data !== 12'o0) begin errors++; $display("[TB] FAIL async_ifu_data got %0o expected 0", ifu_rd_data); end
    checks++; if (exec_rd_data !== 12'o0) begin errors++; $display("[TB] FAIL async_exec_data got %0o expected 0", exec_rd_data); end
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("[TB] FAIL async_wr_drop got %0b expected 0", wr_drop); end
    checks++; if (ifu_rd_count !== 16'd0) begin errors++; $display("[TB] FAIL async_ifu_count got %0d expected 0", ifu_rd_count); end
    checks++; if (exec_rd_count !== 16'd0) begin errors++; $display("[TB] FAIL async_exec_rd_count got %0d expected 0", exec_rd_count); end
    checks++; if (exec_wr_count !== 16'd0) begin errors++; $display("[TB] FAIL async_exec_wr_count got %0d expected 0", exec_wr_count); end
    exec_wr_req  = 1'b1;
    exec_wr_addr = 12'o0600;
    exec_wr_data = 12'o3333;
    step();
    reset = 1'b0;
    checks++; if (exec_wr_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_wr_count got %0d expected 0", exec_wr_count); end
    ifu_rd_req   = 1'b1;
    ifu_rd_addr  = 12'o0200;
    exec_rd_req  = 1'b1;
    exec_rd_addr = 12'o0600;
    step();
    checks++; if (ifu_rd_data !== 12'o1234) begin errors++; $display("[TB] FAIL mem_survives got %0o expected 1234", ifu_rd_data); end
    checks++; if (exec_rd_data !== 12'o0707) begin errors++; $display("[TB] FAIL no_write_in_reset got %0o expected 0707", exec_rd_data); end
  endtask

  task automatic test_saturation();
    pulse_reset();
    ifu_rd_req  = 1'b1;
    ifu_rd_addr = 12'o0200;
    repeat (65534) @(negedge clk);
    checks++; if (ifu_rd_count !== 16'hFFFE) begin errors++; $display("[TB] FAIL sat_before got %0o expected 177776", ifu_rd_count); end
    @(negedge clk);
    checks++; if (ifu_rd_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_reach got %0o expected 177777", ifu_rd_count); end
    repeat (2) @(negedge clk);
    idle_inputs();
    checks++; if (ifu_rd_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_hold got %0o expected 177777", ifu_rd_count); end
    checks++; if (ifu_rd_data !== 12'o1234) begin errors++; $display("[TB] FAIL sat_data got %0o expected 1234", ifu_rd_data); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_preload_fetch();
    test_write_read_same();
    test_dual_read();
    test_load_collision();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
